mca_tdm_multi_as_adder: RTL and testbench
=========================================

Name: mca_tdm_multi_as_adder

Overview:
- Generalised FIR-summation engine for the digital estimator: sample = Σ over n<N, k<K of (S[k][n] ? +h[n][k] : −h[n][k]).
- Supports up to 16 analog states, each with its own coefficient-width reduction.
- Time-multiplexed: P terms are added per clock under a start/busy/valid handshake, with optional output saturation.
- Replaces the fixed per-state adder tree plus final adder in the estimator datapath.

Parameters:
- K, 256, FIR taps per analog state; multiple of 4, range 4..512.
- N, 8, analog states; range 1..16.
- WIDTH_COEFFICIENT, 32, coefficient and output width; 4..32.
- MCA_NUM_ADDITIONS, 16, terms consumed per clock (P); 1..64.
- REDUCE, all zeros, packed array [16] of int; REDUCE[n] is the number of coefficient MSBs dropped for state n; each value is 0..WIDTH_COEFFICIENT−2.
- SATURATE, 1, 1 = clamp output to the signed range; 0 = two's-complement wrap.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request a new sample computation.
- H_matrix, input, [N][K][WIDTH_COEFFICIENT], signed coefficients; bits at or above WIDTH_COEFFICIENT−REDUCE[n] are ignored.
- S_matrix, input, [K][N], control bits; sampled only on an accepted start.
- busy, output, 1, computation in progress.
- valid, output, 1, one-cycle pulse; sample is new.
- overrun, output, 1, one-cycle pulse; start was dropped while busy.
- sample, output, WIDTH_COEFFICIENT, signed result; held until the next valid.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: state=IDLE; busy=0, valid=0, overrun=0, sample=0; accumulator=0, beat counter=0.
- Constants:
  - BEATS = ceil(N*K/P).
  - ACC_W = WIDTH_COEFFICIENT + clog2(N*K) + 1.
- Term mapping: flat index i = n*K + k. Term = sign-extend(h[n][k][WIDTH_COEFFICIENT−REDUCE[n]−1:0]) to ACC_W; negate it when S[k][n]=0. Indices i ≥ N*K contribute 0.
- FSM states: IDLE, ACCUM, OUT.
  - IDLE: busy=0. If start=1: latch S_matrix into an internal register, clear the accumulator and beat counter, go to ACCUM.
  - ACCUM: busy=1. Each cycle add the P terms with indices beat*P .. beat*P+P−1 to the accumulator and increment beat. After the beat BEATS−1 add, load sample and go to OUT.
  - OUT: busy=0, valid=1 for exactly this cycle. If start=1, act as in IDLE and go to ACCUM; otherwise go to IDLE.
- Latency: start accepted in cycle t means valid=1 and the new sample in cycle t+BEATS+1. Maximum throughput is one sample per BEATS+1 cycles.
- Output conversion:
  - SATURATE=1: an accumulator above 2^(W−1)−1 gives 2^(W−1)−1; below −2^(W−1) gives −2^(W−1).
  - SATURATE=0: sample = accumulator[W−1:0].
- Overrun: start=1 during ACCUM is ignored. In that case overrun=1 the next cycle, and the computation in flight and its S snapshot are unaffected.
- H_matrix must be stable from the accepted start until valid. It is not latched.
- Reset during ACCUM: the computation is aborted and the state returns to IDLE. No valid is issued, and sample returns to 0.
- Single-beat case: when N*K ≤ P, BEATS=1 and ACCUM lasts one cycle.
- Adder structure: per-cycle P-input summation as a balanced tree. Combinational only within the beat; no extra pipeline stage.

Decomposition:
- FIR_pkg additions:
  - mca_state_e enum (IDLE, ACCUM, OUT).
  - function mca_beats(N, K, P).
  - function mca_acc_width(W, N, K).
  - function sat_to_width, used for saturation.
  - constant MCA_MAX_N = 16.
- Sub-module: mca_term_tree. It takes P signed ACC_W terms and returns their sum, with combinational balanced pairwise addition. It is instantiated once and is reusable by the downsampling estimators.

Test Plan:
- Baseline: N=2, K=4, P=2, W=8; all h=1, all S=1; start at t → busy t+1..t+4; valid and sample=8 at t+5; busy=0 at t+5.
- All S=0 with the same h → sample=−8 (8'hF8) at t+5.
- Saturation: all h=127, all S=1 (sum 1016). SATURATE=1 → sample=127. SATURATE=0 → sample=8'hF8 (1016 mod 256).
- Width reduction: REDUCE[1]=4, h[1][k]=8'h18, h[0][k]=0, all S=1 → state-1 term = −8 each; sample=−32.
- Handshake:
  - start held high at t+2 (ACCUM) → overrun=1 at t+3; sample=8 at t+5 is unchanged.
  - start=1 in the OUT cycle t+5 → next valid at t+10.
- Reset at t+2 mid-ACCUM → at t+3: busy=0, sample=0; no valid in the next 10 cycles; a fresh start then completes normally with valid at start+5.

Source files
------------

// File: rtl/mca_tdm_multi_as_adder_pkg.sv
// Shared types and sizing helpers for the time-multiplexed multi-add engine.
// Latency: n/a (package); backpressure: n/a.
package mca_tdm_multi_as_adder_pkg;

    localparam int MCA_MAX_N = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } mca_state_e;

    function automatic int mca_beats(input int n, input int k, input int p);
        return (n * k + p - 1) / p;
    endfunction

    function automatic int mca_acc_width(input int w, input int n, input int k);
        return w + $clog2(n * k) + 1;
    endfunction

    // Clamps to the signed range of 'width' bits when saturate is set; the caller
    // keeps the low 'width' bits, which gives plain wrap when saturate is clear.
    function automatic logic [63:0] sat_to_width(input logic signed [63:0] value,
                                                 input int width,
                                                 input bit saturate);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (saturate && (value > max_v)) return max_v;
        if (saturate && (value < min_v)) return min_v;
        return value;
    endfunction

endpackage

// File: rtl/mca_tdm_multi_as_adder_if.sv
// Start/busy/valid bundle for the multi-add engine, with coefficient and control matrices.
// Latency: n/a; backpressure: none, a start while busy is dropped and flagged as overrun.
interface mca_tdm_multi_as_adder_if #(
    parameter int N                 = 8,
    parameter int K                 = 256,
    parameter int WIDTH_COEFFICIENT = 32
);
    logic                                        start;
    logic [N-1:0][K-1:0][WIDTH_COEFFICIENT-1:0]  H_matrix;
    logic [K-1:0][N-1:0]                         S_matrix;
    logic                                        busy;
    logic                                        valid;
    logic                                        overrun;
    logic [WIDTH_COEFFICIENT-1:0]                sample;

    modport master (
        output start, H_matrix, S_matrix,
        input  busy, valid, overrun, sample
    );

    modport slave (
        input  start, H_matrix, S_matrix,
        output busy, valid, overrun, sample
    );
endinterface

// File: rtl/mca_tdm_multi_as_adder_term_tree.sv
// Balanced pairwise sum of P equal-width two's-complement terms.
// Latency: combinational; backpressure: none.
module mca_term_tree #(
    parameter int P     = 16,
    parameter int ACC_W = 42
) (
    input  logic [P-1:0][ACC_W-1:0] terms,
    output logic [ACC_W-1:0]        sum
);
    localparam int LEVELS = (P > 1) ? $clog2(P) : 0;
    localparam int LEAVES = 1 << LEVELS;

    // Heap layout: node j has children 2j+1 and 2j+2, leaves start at LEAVES-1.
    logic [ACC_W-1:0] node [2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < P) begin : g_term
            assign node[LEAVES-1+i] = terms[i];
        end else begin : g_pad
            assign node[LEAVES-1+i] = '0;
        end
    end

    for (genvar j = 0; j < LEAVES - 1; j++) begin : g_node
        assign node[j] = node[2*j+1] + node[2*j+2];
    end

    assign sum = node[0];
endmodule

// File: rtl/mca_tdm_multi_as_adder.sv
// Signed FIR summation of +/-h[n][k] terms selected by S, P terms per clock.
// Latency: valid BEATS+1 cycles after an accepted start; backpressure: start while busy is dropped, overrun pulses.
module mca_tdm_multi_as_adder
    import mca_tdm_multi_as_adder_pkg::*;
#(
    parameter int                         K                 = 256,
    parameter int                         N                 = 8,
    parameter int                         WIDTH_COEFFICIENT = 32,
    parameter int                         MCA_NUM_ADDITIONS = 16,
    parameter bit [MCA_MAX_N-1:0][31:0]   REDUCE            = '0,
    parameter bit                         SATURATE          = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    mca_tdm_multi_as_adder_if.slave bus
);
    localparam int W      = WIDTH_COEFFICIENT;
    localparam int P      = MCA_NUM_ADDITIONS;
    localparam int NK     = N * K;
    localparam int BEATS  = mca_beats(N, K, P);
    localparam int ACC_W  = mca_acc_width(W, N, K);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    mca_state_e           state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [K-1:0][N-1:0]  s_q, s_d;
    logic [W-1:0]         sample_q, sample_d;
    logic                 overrun_q, overrun_d;

    logic [BEATS-1:0][P-1:0][ACC_W-1:0] term_rows;
    logic [ACC_W-1:0]                   beat_sum;
    logic [ACC_W-1:0]                   acc_sum;
    logic [63:0]                        acc_conv;

    // Every term is formed in parallel; the beat counter picks one row of P per clock.
    for (genvar n = 0; n < N; n++) begin : g_state
        localparam int TW = W - int'(REDUCE[n]);
        for (genvar k = 0; k < K; k++) begin : g_tap
            localparam int I = n * K + k;
            logic [ACC_W-1:0] ext;
            assign ext = {{(ACC_W-TW){bus.H_matrix[n][k][TW-1]}}, bus.H_matrix[n][k][TW-1:0]};
            assign term_rows[I/P][I%P] = s_q[k][n] ? ext : -ext;
        end
    end

    for (genvar i = NK; i < BEATS * P; i++) begin : g_pad
        assign term_rows[i/P][i%P] = '0;
    end

    mca_term_tree #(
        .P     (P),
        .ACC_W (ACC_W)
    ) u_term_tree (
        .terms (term_rows[beat_q]),
        .sum   (beat_sum)
    );

    assign acc_sum  = acc_q + beat_sum;
    assign acc_conv = sat_to_width({{(64-ACC_W){acc_sum[ACC_W-1]}}, acc_sum}, W, SATURATE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            beat_q    <= '0;
            s_q       <= '0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            beat_q    <= beat_d;
            s_q       <= s_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        beat_d    = beat_q;
        s_d       = s_q;
        sample_d  = sample_q;
        overrun_d = 1'b0;
        unique case (state_q)
            IDLE, OUT: begin
                if (bus.start) begin
                    s_d     = bus.S_matrix;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                overrun_d = bus.start;
                acc_d     = acc_sum;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    sample_d = acc_conv[W-1:0];
                    state_d  = OUT;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q == ACCUM);
    assign bus.valid   = (state_q == OUT);
    assign bus.overrun = overrun_q;
    assign bus.sample  = sample_q;
endmodule

// File: tb/tb_mca_tdm_multi_as_adder.sv
// Scoreboard bench: two engines (saturating/no reduction, wrapping/REDUCE[1]=4) share stimulus.
// Expected samples come from a plain-arithmetic model of the summation.
module tb_mca_tdm_multi_as_adder;
    import mca_tdm_multi_as_adder_pkg::*;

    localparam int N = 2;
    localparam int K = 4;
    localparam int W = 8;
    localparam int P = 2;
    localparam bit [MCA_MAX_N-1:0][31:0] RED_B = 512'(4) << 32;

    typedef logic [N-1:0][K-1:0][W-1:0] hmat_t;
    typedef logic [K-1:0][N-1:0]        smat_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_a [$];
    logic [W-1:0] exp_b [$];

    always #5 clk = ~clk;

    mca_tdm_multi_as_adder_if #(.N(N), .K(K), .WIDTH_COEFFICIENT(W)) ifa ();
    mca_tdm_multi_as_adder_if #(.N(N), .K(K), .WIDTH_COEFFICIENT(W)) ifb ();

    mca_tdm_multi_as_adder #(
        .K(K), .N(N), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(P),
        .REDUCE('0), .SATURATE(1'b1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    mca_tdm_multi_as_adder #(
        .K(K), .N(N), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(P),
        .REDUCE(RED_B), .SATURATE(1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    function automatic logic [W-1:0] model(input hmat_t h, input smat_t s, input int red1, input bit sat);
        longint acc = 0;
        for (int n = 0; n < N; n++) begin
            int tw = W - ((n == 1) ? red1 : 0);
            for (int k = 0; k < K; k++) begin
                longint v = longint'(int'(h[n][k]) & ((1 << tw) - 1));
                if (v >= (longint'(1) << (tw - 1))) v = v - (longint'(1) << tw);
                acc = s[k][n] ? acc + v : acc - v;
            end
        end
        if (sat && acc > 127) acc = 127;
        if (sat && acc < -128) acc = -128;
        return W'(acc);
    endfunction

    function automatic hmat_t fill_h(input logic [W-1:0] h0, input logic [W-1:0] h1);
        hmat_t h;
        for (int k = 0; k < K; k++) begin
            h[0][k] = h0;
            h[1][k] = h1;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic st);
        ifa.start = st;
        ifb.start = st;
    endtask

    task automatic start_pulse(input hmat_t h, input smat_t s, input bit push);
        ifa.H_matrix = h;
        ifb.H_matrix = h;
        ifa.S_matrix = s;
        ifb.S_matrix = s;
        set_start(1'b1);
        if (push) begin
            exp_a.push_back(model(h, s, 0, 1'b1));
            exp_b.push_back(model(h, s, 4, 1'b0));
        end
        tick();
        set_start(1'b0);
    endtask

    // Called in cycle t+1 of an accepted start; returns just after the valid cycle's negedge.
    task automatic expect_run(input bit hold);
        for (int c = 1; c <= 4; c++) begin
            if (hold && c == 2) set_start(1'b1);
            @(negedge clk);
            chk("busy_a", 32'(ifa.busy), 1);
            chk("busy_b", 32'(ifb.busy), 1);
            chk("valid_early", 32'(ifa.valid | ifb.valid), 0);
            chk("overrun_a", 32'(ifa.overrun), 32'(hold && c == 3));
            tick();
            if (hold && c == 2) set_start(1'b0);
        end
        @(negedge clk);
        chk("valid_a", 32'(ifa.valid), 1);
        chk("valid_b", 32'(ifb.valid), 1);
        chk("busy_out", 32'(ifa.busy | ifb.busy), 0);
        chk("overrun_b", 32'(ifb.overrun), 0);
    endtask

    // Monitor: pops the scoreboard on every valid.
    initial begin
        forever begin
            @(negedge clk);
            if (ifa.valid) begin
                if (exp_a.size() == 0) chk("unexpected_valid_a", 1, 0);
                else chk("sample_a", 32'(ifa.sample), 32'(exp_a.pop_front()));
            end
            if (ifb.valid) begin
                if (exp_b.size() == 0) chk("unexpected_valid_b", 1, 0);
                else chk("sample_b", 32'(ifb.sample), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        hmat_t h;
        smat_t s;
        reset = 1'b1;
        set_start(1'b0);
        ifa.H_matrix = '0;
        ifb.H_matrix = '0;
        ifa.S_matrix = '0;
        ifb.S_matrix = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(ifa.busy | ifb.busy), 0);
        chk("rst_valid", 32'(ifa.valid | ifb.valid), 0);
        chk("rst_overrun", 32'(ifa.overrun | ifb.overrun), 0);
        chk("rst_sample_a", 32'(ifa.sample), 0);
        chk("rst_sample_b", 32'(ifb.sample), 0);
        tick();

        // Directed: baseline, all-negative, saturation/wrap, width reduction.
        start_pulse(fill_h(8'd1, 8'd1), '1, 1'b1);
        expect_run(1'b0);
        tick();
        start_pulse(fill_h(8'd1, 8'd1), '0, 1'b1);
        expect_run(1'b0);
        tick();
        start_pulse(fill_h(8'd127, 8'd127), '1, 1'b1);
        expect_run(1'b0);
        tick();
        start_pulse(fill_h(8'h00, 8'h18), '1, 1'b1);
        expect_run(1'b0);
        tick();

        // Start held during ACCUM is dropped; then a start in the OUT cycle chains.
        start_pulse(fill_h(8'd1, 8'd1), '1, 1'b1);
        expect_run(1'b1);
        start_pulse(fill_h(8'h00, 8'h18), '1, 1'b1);
        expect_run(1'b0);
        tick();

        // Reset mid-computation aborts without a valid.
        start_pulse(fill_h(8'd5, 8'd3), '1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(ifa.busy | ifb.busy), 0);
        chk("abort_sample_a", 32'(ifa.sample), 0);
        chk("abort_sample_b", 32'(ifb.sample), 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            chk("abort_no_valid", 32'(ifa.valid | ifb.valid), 0);
        end
        tick();
        start_pulse(fill_h(8'd1, 8'd1), '1, 1'b1);
        expect_run(1'b0);
        tick();

        // Random transactions with random holds and chaining.
        for (int t = 0; t < 24; t++) begin
            bit chain;
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    h[n][k] = W'($urandom);
            s = smat_t'($urandom);
            start_pulse(h, s, 1'b1);
            expect_run(1'($urandom_range(0, 1)));
            chain = 1'($urandom_range(0, 1));
            if (!chain) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (3) tick();
        chk("drain_a", 32'(exp_a.size()), 0);
        chk("drain_b", 32'(exp_b.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
